// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage with PC, req/ack memory port and
//             valid/stall handoff to decode, including deferred redirects.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                    DATABUS_SIZE   = 16,
    parameter int                    ADDR_BUS_WIDTH = 16,
    parameter logic [ADDR_BUS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req,
    output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
    input  logic                      mem_ack,
    input  logic [DATABUS_SIZE-1:0]   mem_rdata,
    input  logic                      branch_taken,
    input  logic [ADDR_BUS_WIDTH-1:0] branch_target,
    input  logic                      stall,
    output logic                      instr_valid,
    output logic [DATABUS_SIZE-1:0]   instr,
    output logic [ADDR_BUS_WIDTH-1:0] instr_pc
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [ADDR_BUS_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [ADDR_BUS_WIDTH-1:0] r_redirect_pc, w_redirect_pc_nxt;
    logic                      r_redirect_pending, w_redirect_pending_nxt;
    logic [DATABUS_SIZE-1:0]   r_instr, w_instr_nxt;
    logic [ADDR_BUS_WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_REQ;
            r_pc               <= RESET_VECTOR;
            r_redirect_pc      <= '0;
            r_redirect_pending <= 1'b0;
            r_instr            <= '0;
            r_instr_pc         <= '0;
        end else begin
            r_state            <= w_state_nxt;
            r_pc               <= w_pc_nxt;
            r_redirect_pc      <= w_redirect_pc_nxt;
            r_redirect_pending <= w_redirect_pending_nxt;
            r_instr            <= w_instr_nxt;
            r_instr_pc         <= w_instr_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        w_pc_nxt               = r_pc;
        w_redirect_pc_nxt      = r_redirect_pc;
        w_redirect_pending_nxt = r_redirect_pending;
        w_instr_nxt            = r_instr;
        w_instr_pc_nxt         = r_instr_pc;
        case (r_state)
            S_REQ: begin
                if (branch_taken && mem_ack) begin
                    w_pc_nxt               = branch_target;
                    w_redirect_pending_nxt = 1'b0;
                end else if (branch_taken) begin
                    // The read in flight must still complete; remember where to go.
                    w_redirect_pc_nxt      = branch_target;
                    w_redirect_pending_nxt = 1'b1;
                end else if (mem_ack && r_redirect_pending) begin
                    w_pc_nxt               = r_redirect_pc;
                    w_redirect_pending_nxt = 1'b0;
                end else if (mem_ack) begin
                    w_instr_nxt    = mem_rdata;
                    w_instr_pc_nxt = r_pc;
                    w_pc_nxt       = r_pc + 1'b1;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    assign mem_req     = (r_state == S_REQ) && !rst;
    assign mem_addr    = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

`default_nettype wire
